// File: rtl/cacheline_adapter.sv
// Cache-line to memory-burst adapter: serves one 256-bit line read or write
// from the cache as a BEATS x BURST_W burst on the main-memory bus.
module cacheline_adapter #(
  parameter int BURST_W  = 64,
  parameter int BEATS    = 4,
  parameter int LINE_W   = 256,
  parameter int S_OFFSET = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic              read_o,
  output logic              write_o,
  output logic [31:0]       address_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic              resp_i
);

  // state | meaning
  // IDLE  | waiting for a cache request
  // READ  | read burst running, collecting beats into line_o
  // WRITE | write burst running, presenting buffered beats on burst_o
  // DONE  | resp_o high for one cycle, then back to IDLE
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINE_W-1:0]  r_buf;
  logic [LINE_W-1:0]  r_line;
  logic [BURST_W-1:0] r_burst;
  logic [31:0]        r_addr;
  logic               r_read;
  logic               r_write;
  logic               r_resp;

  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        w_lo;
  logic [31:0]        w_lo_nxt;

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_lo      = 32'(r_cnt) * 32'(BURST_W);
  assign w_lo_nxt  = 32'(w_cnt_nxt) * 32'(BURST_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_line  <= '0;
      r_burst <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // A simultaneous read and write request is served as a read.
          if (read_i) begin
            r_addr  <= {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
            r_read  <= 1'b1;
            r_state <= S_READ;
          end else if (write_i) begin
            r_addr  <= {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
            r_buf   <= line_i;
            r_burst <= line_i[BURST_W-1:0];
            r_write <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_READ: begin
          if (resp_i) begin
            r_line[w_lo +: BURST_W] <= burst_i;
            r_cnt <= w_cnt_nxt;
            if (r_cnt == LAST_BEAT) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          if (resp_i) begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == LAST_BEAT) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_burst <= r_buf[w_lo_nxt +: BURST_W];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign line_o    = r_line;
  assign resp_o    = r_resp;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign address_o = r_addr;
  assign burst_o   = r_burst;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter: a memory/cache driver plus a
// line-level reference model (last completed read line, expected beats).
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [31:0]  address_i = '0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o;
  logic         read_o;
  logic         write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i = '0;
  logic         resp_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] m_line = '0;

  cacheline_adapter dut (
    .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .read_o(read_o), .write_o(write_o), .address_o(address_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] outs_all();
    return {line_o[255:104], address_o, burst_o, resp_o, read_o, write_o, 5'b0} | line_o;
  endfunction

  // One cache transaction; data is the line returned by memory (read) or
  // the line handed over by the cache (write).
  task automatic run_txn(input bit rd, input bit both, input logic [31:0] addr,
                         input logic [255:0] data, input int smin, input int smax);
    int stall;
    @(negedge clk);
    read_i    = rd | both;
    write_i   = !rd | both;
    address_i = addr;
    line_i    = rd ? rand_line() : data;
    resp_i    = 1'b0;
    @(negedge clk);
    chk("req_start", 256'({read_o, write_o, resp_o}), rd ? 256'd4 : 256'd2);
    chk("addr", 256'(address_o), 256'({addr[31:5], 5'b0}));
    address_i = $urandom;
    line_i    = rand_line();
    for (int b = 0; b < 4; b++) begin
      stall = $urandom_range(smax, smin);
      for (int s = 0; s <= stall; s++) begin
        if (!rd) chk("wbeat", 256'(burst_o), 256'(data[b*64 +: 64]));
        chk("busy", 256'({read_o, write_o, resp_o}), rd ? 256'd4 : 256'd2);
        chk("addr_hold", 256'(address_o), 256'({addr[31:5], 5'b0}));
        resp_i  = (s == stall);
        burst_i = (s == stall) ? data[b*64 +: 64] : {$urandom, $urandom};
        @(negedge clk);
      end
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    if (rd) m_line = data;
    chk("resp_hi", 256'({read_o, write_o, resp_o}), 256'd1);
    chk("line", line_o, m_line);
    @(negedge clk);
    chk("resp_pulse", 256'({read_o, write_o, resp_o}), 256'd0);
    chk("line_hold", line_o, m_line);
  endtask

  initial begin
    logic [255:0] l;
    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      read_i = 1'($urandom); write_i = 1'($urandom); resp_i = 1'($urandom);
      address_i = $urandom; line_i = rand_line(); burst_i = {$urandom, $urandom};
      #1 chk("rst_outs", outs_all(), 256'd0);
    end
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_outs", outs_all(), 256'd0);
    end

    // Directed back-to-back and stalled reads
    l = {{8{8'hD3}}, {8{8'hC2}}, {8{8'hB1}}, {8{8'hA0}}};
    run_txn(1'b1, 1'b0, 32'h1234_5678, l, 0, 0);
    run_txn(1'b1, 1'b0, 32'h1234_5678, l, 2, 2);

    // Directed write
    l = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
    run_txn(1'b0, 1'b0, 32'hCAFE_F00D, l, 0, 0);

    // Reset mid-read after two beats
    @(negedge clk);
    read_i = 1'b1; address_i = 32'hDEAD_BEE0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    resp_i = 1'b0; read_i = 1'b0;
    rst_n = 1'b0;
    #1 chk("midrst_outs", outs_all(), 256'd0);
    m_line = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 1'b0, 32'h0000_1000, rand_line(), 0, 1);

    // Read and write requested together: read only
    run_txn(1'b1, 1'b1, $urandom, rand_line(), 0, 2);

    // resp_i strobes while idle are ignored
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_resp", 256'({read_o, write_o, resp_o}), 256'd0);
      chk("idle_line", line_o, m_line);
    end
    resp_i = 1'b0;

    // Randomized mix
    for (int t = 0; t < 12; t++)
      run_txn(1'($urandom), 1'b0, $urandom, rand_line(), 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
